// File: rtl/alu_share_arbiter.sv
// Shares one 32-bit ALU between two valid/ready requesters; grant is combinational, result lands one cycle later.
// Latency 1 cycle; a port whose one-entry response buffer is full and not draining is not granted.
module alu_share_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_A,
    input  logic [31:0] req0_B,
    input  logic [2:0]  req0_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_sign,
    output logic        rsp0_zero,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_A,
    input  logic [31:0] req1_B,
    input  logic [2:0]  req1_op,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_sign,
    output logic        rsp1_zero
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

    buf_state_t  state0, state1, state0_nxt, state1_nxt;
    logic        rr_ptr, rr_ptr_nxt;
    logic        elig0, elig1, grant0, grant1;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [2:0]  alu_op;

    // Grant arbitration; Reset low blocks every grant.
    always_comb begin
        elig0  = Reset && req0_valid && ((state0 == EMPTY) || rsp0_ready);
        elig1  = Reset && req1_valid && ((state1 == EMPTY) || rsp1_ready);
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            if (FIXED_PRIO || !rr_ptr) grant0 = 1'b1;
            else                       grant1 = 1'b1;
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = (state0 == FULL);
    assign rsp1_valid = (state1 == FULL);

    always_comb begin
        alu_a  = grant1 ? req1_A  : req0_A;
        alu_b  = grant1 ? req1_B  : req0_B;
        alu_op = grant1 ? req1_op : req0_op;
    end

    always_comb begin
        alu_res = 32'd0;
        case (alu_op)
            3'b000: alu_res = alu_a + alu_b;
            3'b001: alu_res = alu_a - alu_b;
            3'b010: alu_res = alu_b << alu_a;
            3'b011: alu_res = alu_a | alu_b;
            3'b100: alu_res = alu_a & alu_b;
            3'b101: alu_res = {31'd0, (alu_a < alu_b)};
            3'b110: alu_res = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            3'b111: alu_res = alu_a ^ alu_b;
            default: alu_res = 32'd0;
        endcase
    end

    // A buffer stays full on a new load or when its consumer is stalling.
    always_comb begin
        state0_nxt = (grant0 || ((state0 == FULL) && !rsp0_ready)) ? FULL : EMPTY;
        state1_nxt = (grant1 || ((state1 == FULL) && !rsp1_ready)) ? FULL : EMPTY;
        rr_ptr_nxt = rr_ptr;
        if (!FIXED_PRIO) begin
            if (grant0)      rr_ptr_nxt = 1'b1;
            else if (grant1) rr_ptr_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state0      <= EMPTY;
            state1      <= EMPTY;
            rr_ptr      <= 1'b0;
            rsp0_result <= 32'd0;
            rsp0_sign   <= 1'b0;
            rsp0_zero   <= 1'b0;
            rsp1_result <= 32'd0;
            rsp1_sign   <= 1'b0;
            rsp1_zero   <= 1'b0;
        end else begin
            state0 <= state0_nxt;
            state1 <= state1_nxt;
            rr_ptr <= rr_ptr_nxt;
            if (grant0) begin
                rsp0_result <= alu_res;
                rsp0_sign   <= alu_res[31];
                rsp0_zero   <= (alu_res == 32'd0);
            end
            if (grant1) begin
                rsp1_result <= alu_res;
                rsp1_sign   <= alu_res[31];
                rsp1_zero   <= (alu_res == 32'd0);
            end
        end
    end

endmodule
